braille_cell_sequencer: RTL and testbench

//   Downstream consumer of the CNN classifier output (out_valid / alpha / led). Queues each

---
 rtl/braille_pkg.sv | 52 +++++
 rtl/braille_result_fifo.sv | 51 +++++
 rtl/braille_cell_sequencer.sv | 121 ++++++++++++
 tb/tb_braille_cell_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/braille_pkg.sv
// Shared definitions for the braille cell sequencer: FSM state codes, ASCII letter
// ranges and the Grade-1 letter-to-dots table.
package braille_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [7:0] LOWER_FIRST = 8'h61;
    localparam logic [7:0] LOWER_LAST  = 8'h7A;
    localparam logic [7:0] UPPER_FIRST = 8'h41;
    localparam logic [7:0] UPPER_LAST  = 8'h5A;

    localparam int ENTRY_W = 11;

    // Bit k is dot k+1: bits 0-2 are the left column, bits 3-5 the right column.
    function automatic logic [5:0] dots_of(input logic [4:0] letter_index);
        logic [5:0] d;
        case (letter_index)
            5'd0:  d = 6'b000001;
            5'd1:  d = 6'b000011;
            5'd2:  d = 6'b001001;
            5'd3:  d = 6'b011001;
            5'd4:  d = 6'b010001;
            5'd5:  d = 6'b001011;
            5'd6:  d = 6'b011011;
            5'd7:  d = 6'b010011;
            5'd8:  d = 6'b001010;
            5'd9:  d = 6'b011010;
            5'd10: d = 6'b000101;
            5'd11: d = 6'b000111;
            5'd12: d = 6'b001101;
            5'd13: d = 6'b011101;
            5'd14: d = 6'b010101;
            5'd15: d = 6'b001111;
            5'd16: d = 6'b011111;
            5'd17: d = 6'b010111;
            5'd18: d = 6'b001110;
            5'd19: d = 6'b011110;
            5'd20: d = 6'b100101;
            5'd21: d = 6'b100111;
            5'd22: d = 6'b111010;
            5'd23: d = 6'b101101;
            5'd24: d = 6'b111101;
            5'd25: d = 6'b110101;
            default: d = 6'b000000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/braille_result_fifo.sv
// Result queue between the classifier and the cell FSM. Registered read; on a
// simultaneous push and pop while full the popped word is the old one.
module braille_result_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic [10:0] din,
    output logic [10:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [10:0]  mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout       <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                dout       <= mem[rd_ptr_reg[AW-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/braille_cell_sequencer.sv
// Queues classifier results and shows each letter on a 6-dot braille cell for a
// fixed hold time, followed by an optional blank gap.
module braille_cell_sequencer
    import braille_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    parameter int CNT_BW      = 27,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_alpha,
    input  logic [2:0] i_class,
    output logic [5:0] o_dots,
    output logic       o_active,
    output logic [2:0] o_class,
    output logic       o_char_err,
    output logic       o_overflow,
    output logic       o_empty
);
    localparam logic [CNT_BW-1:0] HOLD_LAST = CNT_BW'(HOLD_CYCLES - 1);
    localparam logic [CNT_BW-1:0] GAP_LAST  = CNT_BW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]        AFTER_HOLD = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]          state_reg;
    logic [CNT_BW-1:0]   cnt_reg;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic [7:0]          alpha;
    logic                is_lower;
    logic                is_upper;
    logic                char_ok;
    logic [4:0]          letter_idx;

    assign pop = (state_reg == ST_IDLE) && !fifo_empty;

    braille_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (i_valid),
        .pop     (pop),
        .din     ({i_class, i_alpha}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Upper and lower case share one table index.
    always_comb begin
        alpha      = fifo_dout[7:0];
        is_lower   = (alpha >= LOWER_FIRST) && (alpha <= LOWER_LAST);
        is_upper   = (alpha >= UPPER_FIRST) && (alpha <= UPPER_LAST);
        char_ok    = is_lower || is_upper;
        letter_idx = is_lower ? 5'(alpha - LOWER_FIRST) : 5'(alpha - UPPER_FIRST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            o_dots     <= '0;
            o_active   <= 1'b0;
            o_class    <= '0;
            o_char_err <= 1'b0;
            o_overflow <= 1'b0;
            o_empty    <= 1'b1;
        end else begin
            o_char_err <= 1'b0;
            o_empty    <= (state_reg == ST_IDLE) && fifo_empty;
            // A pop in the same cycle frees a slot, so only a true full drops.
            if (i_valid && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (char_ok) begin
                        o_dots    <= dots_of(letter_idx);
                        o_class   <= fifo_dout[10:8];
                        o_active  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_HOLD;
                    end else begin
                        o_char_err <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        o_dots    <= '0;
                        o_active  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= AFTER_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_braille_cell_sequencer.sv
// Self-checking bench: a timestamp-based model of the display schedule checks the
// main instance every cycle; a second instance is built with no blank gap.
module tb_braille_cell_sequencer;
    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_alpha = 8'h00;
    logic [2:0] i_class = 3'd0;
    logic [5:0] o_dots;
    logic       o_active, o_char_err, o_overflow, o_empty;
    logic [2:0] o_class;

    logic       v2 = 1'b0;
    logic [7:0] a2 = 8'h00;
    logic [2:0] c2 = 3'd0;
    logic [5:0] dots2;
    logic       act2, err2, ovf2, empty2;
    logic [2:0] class2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    braille_cell_sequencer #(
        .HOLD_CYCLES (HOLD), .GAP_CYCLES (GAP), .CNT_BW (4), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .reset_n (reset_n), .i_valid (i_valid), .i_alpha (i_alpha),
        .i_class (i_class), .o_dots (o_dots), .o_active (o_active), .o_class (o_class),
        .o_char_err (o_char_err), .o_overflow (o_overflow), .o_empty (o_empty)
    );

    braille_cell_sequencer #(
        .HOLD_CYCLES (HOLD), .GAP_CYCLES (0), .CNT_BW (4), .FIFO_DEPTH (DEPTH)
    ) dut_nogap (
        .clk (clk), .reset_n (reset_n), .i_valid (v2), .i_alpha (a2),
        .i_class (c2), .o_dots (dots2), .o_active (act2), .o_class (class2),
        .o_char_err (err2), .o_overflow (ovf2), .o_empty (empty2)
    );

    // ---------------- reference model ----------------
    function automatic logic [5:0] dot(input int n);
        return 6'(1 << (n - 1));
    endfunction

    // First decade a..j written as dot lists.
    function automatic logic [5:0] base_pattern(input int i);
        case (i)
            0: return dot(1);
            1: return dot(1) | dot(2);
            2: return dot(1) | dot(4);
            3: return dot(1) | dot(4) | dot(5);
            4: return dot(1) | dot(5);
            5: return dot(1) | dot(2) | dot(4);
            6: return dot(1) | dot(2) | dot(4) | dot(5);
            7: return dot(1) | dot(2) | dot(5);
            8: return dot(2) | dot(4);
            default: return dot(2) | dot(4) | dot(5);
        endcase
    endfunction

    // k..t add dot 3; u,v,x,y,z add dots 3 and 6; w is j plus dot 6.
    function automatic logic [5:0] ref_pattern(input int pos);
        if (pos < 10) return base_pattern(pos);
        if (pos < 20) return base_pattern(pos - 10) | dot(3);
        if (pos == 22) return base_pattern(9) | dot(6);
        return base_pattern(pos - 20 - ((pos > 22) ? 1 : 0)) | dot(3) | dot(6);
    endfunction

    function automatic int letter_pos(input logic [7:0] ch);
        if (ch >= 8'h61 && ch <= 8'h7A) return int'(ch) - 32'h61;
        if (ch >= 8'h41 && ch <= 8'h5A) return int'(ch) - 32'h41;
        return -1;
    endfunction

    logic [10:0] mq[$];
    longint      cyc = 0;
    longint      next_pick = 0;
    longint      disp_start = -1;
    longint      disp_end = -1;
    longint      err_edge = -1;
    logic [5:0]  m_dots = 6'd0;
    logic [2:0]  m_class = 3'd0;
    logic        m_ovf = 1'b0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        logic [10:0] e;
        int pos;
        cyc++;
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
            next_pick = 0;
            disp_start = -1;
            disp_end = -1;
            err_edge = -1;
        end else begin
            if (mq.size() != 0 && cyc >= next_pick) begin
                e = mq.pop_front();
                pos = letter_pos(e[7:0]);
                if (pos >= 0) begin
                    disp_start = cyc + 1;
                    disp_end = cyc + 1 + HOLD;
                    m_dots = ref_pattern(pos);
                    m_class = e[10:8];
                    next_pick = cyc + 2 + HOLD + GAP;
                    $display("tb: cyc %0d show %c class %0d dots %b", cyc, e[7:0], e[10:8], m_dots);
                end else begin
                    err_edge = cyc + 1;
                    next_pick = cyc + 2;
                    $display("tb: cyc %0d reject code 0x%h", cyc, e[7:0]);
                end
            end
            if (i_valid) begin
                if (mq.size() < DEPTH) mq.push_back({i_class, i_alpha});
                else begin
                    m_ovf = 1'b1;
                    $display("tb: cyc %0d drop code 0x%h (queue full)", cyc, i_alpha);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_act;
        if (chk_en && reset_n) begin
            exp_act = (cyc >= disp_start) && (cyc < disp_end);
            checks++;
            if (o_active !== exp_act) begin
                failures++;
                $display("FAIL model_active cyc=%0d got=%b exp=%b", cyc, o_active, exp_act);
            end
            checks++;
            if (o_dots !== (exp_act ? m_dots : 6'd0)) begin
                failures++;
                $display("FAIL model_dots cyc=%0d got=%b exp=%b", cyc, o_dots, exp_act ? m_dots : 6'd0);
            end
            if (exp_act) begin
                checks++;
                if (o_class !== m_class) begin
                    failures++;
                    $display("FAIL model_class cyc=%0d got=%0d exp=%0d", cyc, o_class, m_class);
                end
            end
            checks++;
            if (o_char_err !== (cyc == err_edge)) begin
                failures++;
                $display("FAIL model_char_err cyc=%0d got=%b exp=%b", cyc, o_char_err, cyc == err_edge);
            end
            checks++;
            if (o_overflow !== m_ovf) begin
                failures++;
                $display("FAIL model_overflow cyc=%0d got=%b exp=%b", cyc, o_overflow, m_ovf);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] a, input logic [2:0] c);
        @(negedge clk);
        i_valid = 1'b1;
        i_alpha = a;
        i_class = c;
    endtask

    task automatic idle_in();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && cyc >= next_pick && cyc >= disp_end) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s drain got=timeout exp=idle", tag);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (o_empty !== 1'b1) begin
            failures++;
            $display("FAIL %s o_empty got=%b exp=1", tag, o_empty);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_dots, o_active, o_class, o_char_err, o_overflow, o_empty} !== 13'b0000000_000_001) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%b_%b_%b_%b_%b exp=0",
                     o_dots, o_active, o_class, o_char_err, o_overflow, o_empty);
        end
        checks++;
        if ({dots2, act2, class2, err2, ovf2, empty2} !== 13'b0000000_000_001) begin
            failures++;
            $display("FAIL reset_nogap got=%b_%b_%b_%b_%b_%b exp=0",
                     dots2, act2, class2, err2, ovf2, empty2);
        end
        #2 reset_n = 1'b1;
        chk_en = 1;
    endtask

    task automatic test_single();
        int run = 0;
        send(8'h61, 3'd3);
        idle_in();
        @(negedge clk);
        checks++;
        if (o_active !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_early got=%b exp=0", o_active);
        end
        @(negedge clk);
        checks++;
        if (o_dots !== 6'b000001 || o_class !== 3'd3) begin
            failures++;
            $display("FAIL single_a got=%b/%0d exp=000001/3", o_dots, o_class);
        end
        checks++;
        if (o_empty !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_empty got=%b exp=0", o_empty);
        end
        while (o_active === 1'b1 && run < 20) begin
            run++;
            @(negedge clk);
        end
        checks++;
        if (run != HOLD) begin
            failures++;
            $display("FAIL single_hold_len got=%0d exp=%0d", run, HOLD);
        end
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        send(8'h63, 3'd1);
        send(8'h7A, 3'd2);
        send(8'h4B, 3'd5);
        idle_in();
        wait_idle("back_to_back");
        checks++;
        if (o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overflow got=%b exp=0", o_overflow);
        end
    endtask

    task automatic test_bad_char();
        int pulses = 0;
        int act = 0;
        bit seen = 0;
        send(8'h35, 3'd4);
        idle_in();
        repeat (6) begin
            @(negedge clk);
            pulses += int'(o_char_err);
            act += int'(o_active);
        end
        checks++;
        if (pulses != 1 || act != 0) begin
            failures++;
            $display("FAIL bad_char pulses=%0d active=%0d exp=1/0", pulses, act);
        end
        send(8'h6A, 3'd0);
        idle_in();
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (o_active === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || o_dots !== 6'b011010) begin
            failures++;
            $display("FAIL bad_char_then_j got=%b active=%b exp=011010", o_dots, seen);
        end
        wait_idle("bad_char");
    endtask

    task automatic test_overflow();
        send(8'h62, 3'd1);
        repeat (5) send(8'h61 + 8'($urandom_range(0, 25)), 3'($urandom_range(0, 7)));
        idle_in();
        checks++;
        if (o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got=%b exp=1", o_overflow);
        end
        wait_idle("overflow");
        checks++;
        if (o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got=%b exp=1", o_overflow);
        end
    endtask

    task automatic test_reset_mid_hold();
        int act = 0;
        bit seen = 0;
        send(8'h61, 3'd2);
        send(8'h78, 3'd3);
        send(8'h79, 3'd4);
        idle_in();
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (o_active === 1'b1) seen = 1;
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (!seen || {o_dots, o_active, o_class, o_char_err, o_overflow, o_empty} !== 13'b0000000_000_001) begin
            failures++;
            $display("FAIL mid_hold_reset got=%b_%b_%b_%b_%b_%b seen=%b exp=0",
                     o_dots, o_active, o_class, o_char_err, o_overflow, o_empty, seen);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            act += int'(o_active);
        end
        checks++;
        if (act != 0 || o_empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_hold_flush active_cycles=%0d empty=%b exp=0/1", act, o_empty);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        int r;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) a = 8'($urandom_range(0, 255));
            else if (r < 5) a = 8'h61 + 8'($urandom_range(0, 25));
            else a = 8'h41 + 8'($urandom_range(0, 25));
            send(a, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) != 0) begin
                idle_in();
                repeat ($urandom_range(0, 14)) @(negedge clk);
            end
        end
        idle_in();
        wait_idle("random");
    endtask

    task automatic test_gap_zero();
        int hi1 = 0;
        int lo = 0;
        int hi2 = 0;
        bit seen = 0;
        @(negedge clk);
        v2 = 1'b1; a2 = 8'h64; c2 = 3'd6;
        @(negedge clk);
        a2 = 8'h45; c2 = 3'd1;
        @(negedge clk);
        v2 = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (act2 === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || dots2 !== ref_pattern(3) || class2 !== 3'd6) begin
            failures++;
            $display("FAIL nogap_first got=%b/%0d exp=%b/6", dots2, class2, ref_pattern(3));
        end
        while (act2 === 1'b1 && hi1 < 20) begin hi1++; @(negedge clk); end
        while (act2 === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
        checks++;
        if (dots2 !== ref_pattern(4) || class2 !== 3'd1) begin
            failures++;
            $display("FAIL nogap_second got=%b/%0d exp=%b/1", dots2, class2, ref_pattern(4));
        end
        while (act2 === 1'b1 && hi2 < 20) begin hi2++; @(negedge clk); end
        $display("tb: nogap hold=%0d low=%0d hold=%0d", hi1, lo, hi2);
        checks++;
        if (hi1 != HOLD || lo != 2 || hi2 != HOLD) begin
            failures++;
            $display("FAIL nogap_timing got=%0d/%0d/%0d exp=%0d/2/%0d", hi1, lo, hi2, HOLD, HOLD);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_char();
        test_overflow();
        test_reset_mid_hold();
        test_random();
        test_gap_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
